lsu_arbiter: RTL and testbench

// - N-port registered load/store arbiter; next generation of the core's combinational LSU mux.
// - Sits between requesters (fetch, AG, AXI slave, ...) and two targets: local SRAM and the AXI master.
// - Adds selectable round-robin/fixed priority, a registered request stage, an address-window decode
//   and one-outstanding response steering back to the granted port.

---
 rtl/lsu_arbiter_pkg.sv | 18 +
 rtl/lsu_arbiter_rr_arb.sv | 36 +++
 rtl/lsu_arbiter.sv | 122 ++++++++++++
 tb/tb_lsu_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_arbiter_pkg.sv
// Shared types and helpers for the registered load/store arbiter.
// Holds the FSM state encoding and the default SRAM window value.
package lsu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [15:0] SRAM_HI_DEFAULT = 16'h8000;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lsu_arbiter_rr_arb.sv
// Combinational requester selection: round-robin from a pointer, or fixed priority
// where the highest index wins. Produces a one-hot grant and its encoded index.
module rr_arb
  import lsu_arbiter_pkg::*;
#(
  parameter int NPORT = 3,
  localparam int PW = idx_width(NPORT)
) (
  input  logic [NPORT-1:0] req,
  input  logic [PW-1:0]    ptr,
  input  logic             rr_mode,
  output logic [NPORT-1:0] gnt,
  output logic [PW-1:0]    idx,
  output logic             any
);

  assign any = |req;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    idx = '0;
    if (rr_mode) begin
      // Walk from the farthest candidate back to ptr so the nearest requester is written last.
      for (int k = NPORT - 1; k >= 0; k--) begin
        if (req[(int'(ptr) + k) % NPORT]) idx = PW'((int'(ptr) + k) % NPORT);
      end
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (req[i]) idx = PW'(i);
      end
    end
  end

  assign gnt = any ? (NPORT'(1) << idx) : '0;

endmodule

// File: rtl/lsu_arbiter.sv
// N-port registered load/store arbiter: one request at a time is accepted, issued to
// SRAM or the AXI master by address window, and its completion steered back to its port.
module lsu_arbiter
  import lsu_arbiter_pkg::*;
#(
  parameter int          NPORT   = 3,
  parameter int          AW      = 32,
  parameter int          DW      = 32,
  parameter logic [15:0] SRAM_HI = SRAM_HI_DEFAULT,
  parameter bit          RR      = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORT-1:0]        hs_req_val,
  output logic [NPORT-1:0]        hs_req_rdy,
  input  logic [NPORT*AW-1:0]     i_req_adr,
  input  logic [NPORT*DW-1:0]     i_req_wdat,
  input  logic [NPORT*DW/8-1:0]   i_req_wen,
  input  logic [NPORT-1:0]        i_req_ren,
  output logic [NPORT-1:0]        hs_rsp_val,
  output logic [DW-1:0]           o_rsp_rdat,
  output logic                    hs_ls4ram_val,
  input  logic                    hs_ram4ls_rdy,
  output logic                    hs_ls4axim_val,
  input  logic                    hs_axim4ls_rdy,
  output logic [AW-1:0]           o_adr,
  output logic [DW-1:0]           o_wdat,
  output logic [DW/8-1:0]         o_wen,
  output logic                    o_ren,
  input  logic                    i_ram_rsp_val,
  input  logic [DW-1:0]           i_ram_rdat,
  input  logic                    i_axim_rsp_val,
  input  logic [DW-1:0]           i_axim_rdat,
  output logic                    o_busy
);

  localparam int PW = idx_width(NPORT);
  localparam int BW = DW / 8;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, gnt_idx, g_r;
  logic [NPORT-1:0] gnt;
  logic            gnt_any, accept, issuing;
  logic [AW-1:0]   adr_r, req_adr;
  logic [DW-1:0]   wdat_r, rdat_r;
  logic [BW-1:0]   wen_r, req_wen;
  logic            ren_r, req_ren, sel_ram_r;
  logic            tgt_rdy, tgt_rsp;
  logic [DW-1:0]   tgt_rdat;

  rr_arb #(.NPORT(NPORT)) u_arb (
    .req     (hs_req_val),
    .ptr     (ptr),
    .rr_mode (RR),
    .gnt     (gnt),
    .idx     (gnt_idx),
    .any     (gnt_any)
  );

  assign accept  = (state == ST_IDLE) && gnt_any;
  assign req_adr = i_req_adr[gnt_idx*AW +: AW];
  assign req_wen = i_req_wen[gnt_idx*BW +: BW];
  assign req_ren = i_req_ren[gnt_idx];

  // Only the target chosen at accept time may advance the FSM.
  assign tgt_rdy  = sel_ram_r ? hs_ram4ls_rdy  : hs_axim4ls_rdy;
  assign tgt_rsp  = sel_ram_r ? i_ram_rsp_val  : i_axim_rsp_val;
  assign tgt_rdat = sel_ram_r ? i_ram_rdat     : i_axim_rdat;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = (req_wen == '0 && !req_ren) ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (tgt_rdy) state_nxt = ST_WAIT;
      ST_WAIT:  if (tgt_rsp) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign issuing        = (state == ST_ISSUE);
  assign hs_req_rdy     = accept ? gnt : '0;
  assign hs_ls4ram_val  = issuing && sel_ram_r;
  assign hs_ls4axim_val = issuing && !sel_ram_r;
  assign o_adr          = issuing ? adr_r  : '0;
  assign o_wdat         = issuing ? wdat_r : '0;
  assign o_wen          = issuing ? wen_r  : '0;
  assign o_ren          = issuing && ren_r;
  assign hs_rsp_val     = (state == ST_RESP) ? (NPORT'(1) << g_r) : '0;
  assign o_rsp_rdat     = (state == ST_RESP) ? rdat_r : '0;
  assign o_busy         = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      g_r       <= '0;
      adr_r     <= '0;
      wdat_r    <= '0;
      wen_r     <= '0;
      ren_r     <= 1'b0;
      sel_ram_r <= 1'b0;
      rdat_r    <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      state <= state_nxt;
      if (accept) begin
        g_r       <= gnt_idx;
        adr_r     <= req_adr;
        wdat_r    <= i_req_wdat[gnt_idx*DW +: DW];
        wen_r     <= req_wen;
        ren_r     <= req_ren;
        sel_ram_r <= (req_adr[AW-1 -: 16] == SRAM_HI);
        rdat_r    <= '0;
        if (RR) ptr <= (int'(gnt_idx) == NPORT - 1) ? '0 : gnt_idx + 1'b1;
      end
      // Pure writes complete with zero data; anything with ren returns the target's data.
      if (state == ST_WAIT && tgt_rsp) rdat_r <= ren_r ? tgt_rdat : '0;
    end
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Self-checking bench for lsu_arbiter: one round-robin and one fixed-priority instance
// share stimulus; the bench plays requesters and both targets.
module tb_lsu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  req_val = '0;
  logic [31:0] p_adr  [3];
  logic [31:0] p_wdat [3];
  logic [3:0]  p_wen  [3];
  logic        p_ren  [3];
  logic [95:0] adr_bus, wdat_bus;
  logic [11:0] wen_bus;
  logic [2:0]  ren_bus;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      adr_bus[p*32 +: 32]  = p_adr[p];
      wdat_bus[p*32 +: 32] = p_wdat[p];
      wen_bus[p*4 +: 4]    = p_wen[p];
      ren_bus[p]           = p_ren[p];
    end
  end

  logic        ram_rdy = 0, axi_rdy = 0, ram_rsp = 0, axi_rsp = 0;
  logic [31:0] ram_rdat = '0, axi_rdat = '0;

  logic [2:0]  d_rdy [2], d_rsp [2];
  logic [31:0] d_rdat [2], d_adr [2], d_wdat [2];
  logic [3:0]  d_wen [2];
  logic        d_ram_val [2], d_axi_val [2], d_ren [2], d_busy [2];

  lsu_arbiter #(.RR(1'b1)) u_rr (
    .clk(clk), .rst(rst), .hs_req_val(req_val), .hs_req_rdy(d_rdy[0]),
    .i_req_adr(adr_bus), .i_req_wdat(wdat_bus), .i_req_wen(wen_bus), .i_req_ren(ren_bus),
    .hs_rsp_val(d_rsp[0]), .o_rsp_rdat(d_rdat[0]),
    .hs_ls4ram_val(d_ram_val[0]), .hs_ram4ls_rdy(ram_rdy),
    .hs_ls4axim_val(d_axi_val[0]), .hs_axim4ls_rdy(axi_rdy),
    .o_adr(d_adr[0]), .o_wdat(d_wdat[0]), .o_wen(d_wen[0]), .o_ren(d_ren[0]),
    .i_ram_rsp_val(ram_rsp), .i_ram_rdat(ram_rdat),
    .i_axim_rsp_val(axi_rsp), .i_axim_rdat(axi_rdat), .o_busy(d_busy[0]));

  lsu_arbiter #(.RR(1'b0)) u_fx (
    .clk(clk), .rst(rst), .hs_req_val(req_val), .hs_req_rdy(d_rdy[1]),
    .i_req_adr(adr_bus), .i_req_wdat(wdat_bus), .i_req_wen(wen_bus), .i_req_ren(ren_bus),
    .hs_rsp_val(d_rsp[1]), .o_rsp_rdat(d_rdat[1]),
    .hs_ls4ram_val(d_ram_val[1]), .hs_ram4ls_rdy(ram_rdy),
    .hs_ls4axim_val(d_axi_val[1]), .hs_axim4ls_rdy(axi_rdy),
    .o_adr(d_adr[1]), .o_wdat(d_wdat[1]), .o_wen(d_wen[1]), .o_ren(d_ren[1]),
    .i_ram_rsp_val(ram_rsp), .i_ram_rdat(ram_rdat),
    .i_axim_rsp_val(axi_rsp), .i_axim_rdat(axi_rdat), .o_busy(d_busy[1]));

  // The instance currently under observation (0 = round-robin, 1 = fixed).
  int dsel = 0;
  logic [2:0]  cur_rdy, cur_rsp;
  logic [31:0] cur_rdat, cur_adr, cur_wdat;
  logic [3:0]  cur_wen;
  logic        cur_ram_val, cur_axi_val, cur_ren, cur_busy;
  assign cur_rdy     = d_rdy[dsel];
  assign cur_rsp     = d_rsp[dsel];
  assign cur_rdat    = d_rdat[dsel];
  assign cur_adr     = d_adr[dsel];
  assign cur_wdat    = d_wdat[dsel];
  assign cur_wen     = d_wen[dsel];
  assign cur_ram_val = d_ram_val[dsel];
  assign cur_axi_val = d_axi_val[dsel];
  assign cur_ren     = d_ren[dsel];
  assign cur_busy    = d_busy[dsel];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    req_val = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  function automatic int first_set(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Target class of a request: 0 = none (no-op), 1 = SRAM, 2 = AXI.
  function automatic int tgt_of(input logic [31:0] adr, input logic [3:0] wen, input logic ren);
    if (wen == 4'h0 && !ren) return 0;
    return (adr[31:16] == 16'h8000) ? 1 : 2;
  endfunction

  function automatic int model_winner(input logic [2:0] v, input int ptr, input bit rr);
    if (rr) begin
      for (int k = 0; k < 3; k++) if (v[(ptr + k) % 3]) return (ptr + k) % 3;
    end else begin
      for (int p = 2; p >= 0; p--) if (v[p]) return p;
    end
    return -1;
  endfunction

  typedef struct {
    int          acc;
    logic [2:0]  vals;
    logic [2:0]  rdy_vec;
    logic [2:0]  rsp;
    logic [2:0]  rsp_next;
    logic [31:0] rdat;
    bit          ram_seen;
    bit          axi_seen;
    bit          payload_ok;
    bit          wait_clean;
  } res_t;

  // Plays the requester side and the selected target for one transaction.
  task automatic serve(input int stall, input int lat, input logic [31:0] trdat,
                       input bit stray, output res_t r);
    int tgt;
    r.acc = -1; r.vals = '0; r.rdy_vec = '0; r.rsp = '0; r.rsp_next = '0; r.rdat = '0;
    r.ram_seen = 0; r.axi_seen = 0; r.payload_ok = 1; r.wait_clean = 1;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (cur_rdy != 3'b000) begin
        r.rdy_vec = cur_rdy;
        r.vals    = req_val;
        r.acc     = first_set(cur_rdy);
        break;
      end
      step();
    end
    if (r.acc < 0) return;
    tgt = tgt_of(p_adr[r.acc], p_wen[r.acc], p_ren[r.acc]);
    step();
    req_val[r.acc] = 1'b0;
    if (tgt != 0) begin
      for (int i = 0; i <= stall; i++) begin
        settle();
        r.ram_seen |= cur_ram_val;
        r.axi_seen |= cur_axi_val;
        if (cur_adr !== p_adr[r.acc] || cur_wdat !== p_wdat[r.acc] ||
            cur_wen !== p_wen[r.acc] || cur_ren !== p_ren[r.acc]) r.payload_ok = 0;
        if (i == stall) begin
          if (tgt == 1) ram_rdy = 1'b1; else axi_rdy = 1'b1;
        end
        step();
        ram_rdy = 1'b0;
        axi_rdy = 1'b0;
      end
      for (int i = 0; i <= lat; i++) begin
        settle();
        r.ram_seen |= cur_ram_val;
        r.axi_seen |= cur_axi_val;
        if (cur_adr != '0 || cur_wen != '0 || cur_ren || cur_rsp != '0) r.wait_clean = 0;
        if (stray && i == 0) begin
          if (tgt == 1) begin axi_rsp = 1'b1; axi_rdat = 32'hBAD0BAD0; end
          else          begin ram_rsp = 1'b1; ram_rdat = 32'hBAD0BAD0; end
        end
        if (i == lat) begin
          if (tgt == 1) begin ram_rsp = 1'b1; ram_rdat = trdat; end
          else          begin axi_rsp = 1'b1; axi_rdat = trdat; end
        end
        step();
        ram_rsp = 1'b0;
        axi_rsp = 1'b0;
      end
    end
    settle();
    r.rsp  = cur_rsp;
    r.rdat = cur_rdat;
    step();
    settle();
    r.rsp_next = cur_rsp;
  endtask

  task automatic check_txn(input string tag, input res_t r, input int exp_port,
                           input int exp_tgt, input logic [31:0] exp_rdat);
    check({tag, " accept"},   r.rdy_vec, 64'(3'b001 << exp_port));
    check({tag, " rsp port"}, r.rsp, 64'(3'b001 << exp_port));
    check({tag, " rsp once"}, r.rsp_next, 0);
    check({tag, " rdat"},     r.rdat, exp_rdat);
    check({tag, " ram val"},  r.ram_seen, exp_tgt == 1);
    check({tag, " axi val"},  r.axi_seen, exp_tgt == 2);
    check({tag, " payload"},  r.payload_ok, 1);
    check({tag, " wait idle"}, r.wait_clean, 1);
  endtask

  typedef struct {
    int          port;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  wen;
    logic        ren;
    int          stall;
    int          lat;
    logic [31:0] trdat;
    bit          stray;
    int          exp_tgt;
    logic [31:0] exp_rdat;
  } vec_t;

  vec_t vecs [7];
  res_t r;

  initial begin
    for (int p = 0; p < 3; p++) begin
      p_adr[p] = '0; p_wdat[p] = '0; p_wen[p] = '0; p_ren[p] = 1'b0;
    end

    vecs[0] = '{0, 32'h8000_0010, 32'h0,          4'h0, 1'b1, 4, 0, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF};
    vecs[1] = '{1, 32'h1000_0000, 32'h5555_AAAA,  4'h3, 1'b0, 0, 2, 32'h7777_7777, 1, 2, 32'h0};
    vecs[2] = '{2, 32'h8000_FFFC, 32'h0,          4'h0, 1'b1, 0, 0, 32'h1234_5678, 0, 1, 32'h1234_5678};
    vecs[3] = '{0, 32'h7FFF_0000, 32'h0,          4'h0, 1'b1, 1, 1, 32'hCAFE_F00D, 0, 2, 32'hCAFE_F00D};
    vecs[4] = '{1, 32'h8000_0000, 32'h0,          4'h0, 1'b0, 0, 0, 32'h9999_9999, 0, 0, 32'h0};
    vecs[5] = '{2, 32'h8000_0100, 32'hA5A5_A5A5,  4'hF, 1'b1, 2, 0, 32'h0A0B_0C0D, 0, 1, 32'h0A0B_0C0D};
    vecs[6] = '{0, 32'hFFFF_FFF0, 32'h0,          4'h0, 1'b1, 0, 3, 32'h1111_2222, 1, 2, 32'h1111_2222};

    // Reset, then a quiet idle period.
    dsel = 0;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    for (int m = 0; m < 2; m++) begin
      dsel = m;
      settle();
      check("reset rdy/rsp", {cur_rdy, cur_rsp}, 0);
      check("reset target val", {cur_ram_val, cur_axi_val, cur_ren, cur_wen}, 0);
      check("reset adr/data", {cur_adr, cur_wdat | cur_rdat}, 0);
      check("reset busy", cur_busy, 0);
    end

    // Single-requester vectors on the round-robin instance.
    dsel = 0;
    foreach (vecs[i]) begin
      p_adr[vecs[i].port]  = vecs[i].adr;
      p_wdat[vecs[i].port] = vecs[i].wdat;
      p_wen[vecs[i].port]  = vecs[i].wen;
      p_ren[vecs[i].port]  = vecs[i].ren;
      req_val = 3'b001 << vecs[i].port;
      serve(vecs[i].stall, vecs[i].lat, vecs[i].trdat, vecs[i].stray, r);
      check_txn($sformatf("vec%0d", i), r, vecs[i].port, vecs[i].exp_tgt, vecs[i].exp_rdat);
    end

    // Fixed priority: ports 0 and 2 together -> 2 first, 0 on the next IDLE.
    dsel = 1;
    do_reset();
    p_adr[0] = 32'h8000_0200; p_wen[0] = 4'h0; p_ren[0] = 1'b1;
    p_adr[2] = 32'h3000_0000; p_wen[2] = 4'h0; p_ren[2] = 1'b1;
    req_val = 3'b101;
    serve(0, 0, 32'h2222_0002, 0, r);
    check_txn("fixed first", r, 2, 2, 32'h2222_0002);
    serve(0, 0, 32'h2222_0000, 0, r);
    check_txn("fixed second", r, 0, 1, 32'h2222_0000);

    // Round-robin with every port holding val: 0,1,2,0.
    dsel = 0;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      p_adr[p] = 32'h8000_0000 + 32'(p * 4); p_wen[p] = 4'h0; p_ren[p] = 1'b1;
    end
    req_val = 3'b111;
    for (int k = 0; k < 4; k++) begin
      serve(0, 0, 32'hC0DE_0000 + 32'(k), 0, r);
      check_txn($sformatf("rr%0d", k), r, k % 3, 1, 32'hC0DE_0000 + 32'(k));
      if (r.acc >= 0) req_val[r.acc] = 1'b1;
    end
    req_val = '0;

    // Reset while in WAIT drops the transaction.
    dsel = 0;
    do_reset();
    p_adr[1] = 32'h2000_0040; p_wen[1] = 4'h0; p_ren[1] = 1'b1;
    req_val = 3'b010;
    settle();
    check("rstw accept", cur_rdy, 3'b010);
    step();
    req_val = '0;
    axi_rdy = 1'b1;
    step();
    axi_rdy = 1'b0;
    settle();
    check("rstw busy in wait", cur_busy, 1);
    rst = 1'b1;
    #1;
    check("rstw async idle", cur_busy, 0);
    step();
    rst = 1'b0;
    begin
      logic [2:0] seen = '0;
      for (int i = 0; i < 3; i++) begin
        settle();
        seen |= cur_rsp;
        step();
      end
      check("rstw no rsp", seen, 0);
    end
    p_adr[2] = 32'h8000_0400; p_wen[2] = 4'h0; p_ren[2] = 1'b1;
    req_val = 3'b100;
    serve(1, 0, 32'h600D_0001, 0, r);
    check_txn("rstw after", r, 2, 1, 32'h600D_0001);

    // Randomised traffic on both instances against the arbitration rules.
    for (int m = 0; m < 2; m++) begin
      int ptr = 0;
      dsel = m;
      do_reset();
      for (int t = 0; t < 30; t++) begin
        int exp_w, tgt;
        logic [31:0] trdat;
        for (int p = 0; p < 3; p++) begin
          if (!req_val[p] && ($urandom_range(1, 0) == 1 || (req_val == '0 && p == 2))) begin
            p_adr[p]  = ($urandom_range(1, 0) == 1) ? {16'h8000, 16'($urandom)} : $urandom;
            p_wdat[p] = $urandom;
            p_wen[p]  = ($urandom_range(3, 0) == 0) ? 4'h0 : 4'($urandom);
            p_ren[p]  = 1'($urandom);
            req_val[p] = 1'b1;
          end
        end
        trdat = $urandom;
        exp_w = model_winner(req_val, ptr, m == 0);
        tgt   = tgt_of(p_adr[exp_w], p_wen[exp_w], p_ren[exp_w]);
        serve($urandom_range(3, 0), $urandom_range(3, 0), trdat, 1'($urandom), r);
        check_txn($sformatf("rand m%0d t%0d", m, t), r, exp_w, tgt,
                  (tgt != 0 && p_ren[exp_w]) ? trdat : 32'h0);
        if (m == 0) ptr = (exp_w + 1) % 3;
      end
      req_val = '0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
